// File: rtl/record_fn_queue_pkg.sv
// Shared types for the record function queue: function modes, section states
// and the mode legality helper used by the top level.
package record_fn_queue_types;

  typedef enum logic [1:0] {
    FN_WRAP = 2'd0,
    FN_SAT  = 2'd1,
    FN_MAX  = 2'd2
  } fn_mode_t;

  typedef enum logic {
    run   = 1'b0,
    flush = 1'b1
  } record_fn_queue_SECTIONS;

  localparam int MODE_MIN = 0;
  localparam int MODE_MAX = 2;

  // Out-of-range MODE values fall back to the plain wrapping sum.
  function automatic fn_mode_t to_fn_mode(input int mode);
    if (mode < MODE_MIN || mode > MODE_MAX) return FN_WRAP;
    case (mode)
      1:       return FN_SAT;
      2:       return FN_MAX;
      default: return FN_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/record_fn_queue_alu.sv
// Combinational per-record function: wrap sum, saturating sum or max(y, x>=0),
// with a flag telling whether a clamp was applied to this record.
module record_fn_alu
  import record_fn_queue_types::*;
#(
  parameter int       DATA_W = 32,
  parameter fn_mode_t MODE   = FN_WRAP
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] result_o,
  output logic              clamped_o
);

  // Two guard bits: y up to 2^W-1 plus x up to 2^(W-1)-1 overflows W+1 signed bits.
  logic [DATA_W+1:0] x_ext;
  logic [DATA_W+1:0] y_ext;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] x_pos;

  assign x_ext = {{2{x_i[DATA_W-1]}}, x_i};
  assign y_ext = {2'b00, y_i};
  assign sum   = x_ext + y_ext;
  assign x_pos = x_i[DATA_W-1] ? '0 : x_i;

  always_comb begin
    result_o  = sum[DATA_W-1:0];
    clamped_o = 1'b0;
    case (MODE)
      FN_SAT: begin
        if (sum[DATA_W+1]) begin
          result_o  = '0;
          clamped_o = 1'b1;
        end else if (sum[DATA_W]) begin
          result_o  = '1;
          clamped_o = 1'b1;
        end
      end
      FN_MAX: begin
        result_o  = (y_i > x_pos) ? y_i : x_pos;
        clamped_o = x_i[DATA_W-1];
      end
      default: begin
        result_o  = sum[DATA_W-1:0];
        clamped_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/record_fn_queue.sv
// Record function block with a DEPTH-entry result FIFO between sync/notify
// input and output ports; flush clears buffered results but keeps a same-edge push.
module record_fn_queue
  import record_fn_queue_types::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_W-1:0]       b_in_x_i,
  input  logic [DATA_W-1:0]       b_in_y_i,
  input  logic                    b_in_sync_i,
  output logic                    b_in_notify_o,
  output logic [DATA_W-1:0]       b_out_o,
  input  logic                    b_out_sync_i,
  output logic                    b_out_notify_o,
  input  logic                    flush_i,
  output logic                    sat_event_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam fn_mode_t FN_MODE = to_fn_mode(MODE);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              in_notify_q, out_notify_q;
  logic              sat_q;
  record_fn_queue_SECTIONS section_q, section_d;

  logic              push, pop;
  logic [DATA_W-1:0] alu_result;
  logic              alu_clamped;

  record_fn_alu #(
    .DATA_W (DATA_W),
    .MODE   (FN_MODE)
  ) u_alu (
    .x_i       (b_in_x_i),
    .y_i       (b_in_y_i),
    .result_o  (alu_result),
    .clamped_o (alu_clamped)
  );

  assign push = b_in_sync_i & in_notify_q;
  assign pop  = b_out_sync_i & out_notify_q;

  always_comb begin
    section_d = section_q;
    case (section_q)
      run:     if (flush_i) section_d = flush;
      flush:   section_d = run;
      default: section_d = run;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      // Restart at slot 0; a same-edge pop just drops a result that is cleared anyway.
      rd_ptr_d = '0;
      wr_ptr_d = push ? PW'(1) : '0;
      level_d  = push ? LW'(1) : '0;
      if (push) mem_d[0] = alu_result;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = alu_result;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      in_notify_q  <= 1'b1;
      out_notify_q <= 1'b0;
      sat_q        <= 1'b0;
      section_q    <= run;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      in_notify_q  <= (level_d < LW'(DEPTH));
      out_notify_q <= (level_d != '0);
      sat_q        <= push & alu_clamped;
      section_q    <= section_d;
    end
  end

  assign b_in_notify_o  = in_notify_q;
  assign b_out_notify_o = out_notify_q;
  assign b_out_o        = mem_q[rd_ptr_q];
  assign sat_event_o    = sat_q;
  assign level_o        = level_q;

endmodule

// File: tb/tb_record_fn_queue.sv
// Bench: three DATA_W=8, DEPTH=4 instances (MODE 0/1/2) share one stimulus stream
// and are compared against a queue-based reference model.
module tb_record_fn_queue;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] b_in_x = '0;
  logic [W-1:0] b_in_y = '0;
  logic         b_in_sync = 1'b0;
  logic         b_out_sync = 1'b0;
  logic         flush = 1'b0;

  logic         nin [3];
  logic         nout [3];
  logic [W-1:0] bout [3];
  logic         sat [3];
  logic [2:0]   lvl [3];

  int errors = 0;
  int checks = 0;
  int qx[$];
  int qy[$];

  always #5 clk = ~clk;

  record_fn_queue #(.DATA_W(W), .DEPTH(D), .MODE(0)) u_m0 (
    .clk_i(clk), .rst_ni(rst_n), .b_in_x_i(b_in_x), .b_in_y_i(b_in_y),
    .b_in_sync_i(b_in_sync), .b_in_notify_o(nin[0]), .b_out_o(bout[0]),
    .b_out_sync_i(b_out_sync), .b_out_notify_o(nout[0]), .flush_i(flush),
    .sat_event_o(sat[0]), .level_o(lvl[0]));

  record_fn_queue #(.DATA_W(W), .DEPTH(D), .MODE(1)) u_m1 (
    .clk_i(clk), .rst_ni(rst_n), .b_in_x_i(b_in_x), .b_in_y_i(b_in_y),
    .b_in_sync_i(b_in_sync), .b_in_notify_o(nin[1]), .b_out_o(bout[1]),
    .b_out_sync_i(b_out_sync), .b_out_notify_o(nout[1]), .flush_i(flush),
    .sat_event_o(sat[1]), .level_o(lvl[1]));

  record_fn_queue #(.DATA_W(W), .DEPTH(D), .MODE(2)) u_m2 (
    .clk_i(clk), .rst_ni(rst_n), .b_in_x_i(b_in_x), .b_in_y_i(b_in_y),
    .b_in_sync_i(b_in_sync), .b_in_notify_o(nin[2]), .b_out_o(bout[2]),
    .b_out_sync_i(b_out_sync), .b_out_notify_o(nout[2]), .flush_i(flush),
    .sat_event_o(sat[2]), .level_o(lvl[2]));

  function automatic int fn_ref(input int mode, input int x, input int y);
    int s;
    int xp;
    s = x + y;
    if (mode == 0) return s & 255;
    if (mode == 1) return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    xp = (x < 0) ? 0 : x;
    return (y > xp) ? y : xp;
  endfunction

  function automatic int clamp_ref(input int mode, input int x, input int y);
    if (mode == 1) return ((x + y) < 0 || (x + y) > 255) ? 1 : 0;
    if (mode == 2) return (x < 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int es [3]);
    int lv;
    lv = qx.size();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s m%0d level", tag, m), int'(lvl[m]), lv);
      chk($sformatf("%s m%0d in_notify", tag, m), int'(nin[m]), (lv < D) ? 1 : 0);
      chk($sformatf("%s m%0d out_notify", tag, m), int'(nout[m]), (lv > 0) ? 1 : 0);
      chk($sformatf("%s m%0d sat", tag, m), int'(sat[m]), es[m]);
      if (lv > 0)
        chk($sformatf("%s m%0d b_out", tag, m), int'(bout[m]), fn_ref(m, qx[0], qy[0]));
    end
  endtask

  // One clock cycle: drive, let the edge happen, advance the model, check on the falling edge.
  task automatic cyc(input string tag, input bit is, input int x, input int y,
                     input bit os, input bit fl);
    bit push;
    bit pop;
    int es [3];
    b_in_sync  = is;
    b_in_x     = 8'(x);
    b_in_y     = 8'(y);
    b_out_sync = os;
    flush      = fl;
    push = is && (qx.size() < D);
    pop  = os && (qx.size() > 0);
    @(posedge clk);
    if (pop) begin
      void'(qx.pop_front());
      void'(qy.pop_front());
    end
    if (fl) begin
      qx.delete();
      qy.delete();
    end
    for (int m = 0; m < 3; m++) es[m] = push ? clamp_ref(m, x, y) : 0;
    if (push) begin
      qx.push_back(x);
      qy.push_back(y);
    end
    @(negedge clk);
    check_all(tag, es);
  endtask

  initial begin
    int zero3 [3];
    int rx;
    int ry;
    zero3 = '{0, 0, 0};

    // Reset held for three cycles, then released
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all("in_reset", zero3);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("after_reset", zero3);
    for (int m = 0; m < 3; m++) chk($sformatf("reset m%0d b_out", m), int'(bout[m]), 0);

    // Directed arithmetic cases
    cyc("push_-3_10", 1, -3, 10, 0, 0);
    cyc("pop_push_100_200", 1, 100, 200, 1, 0);
    cyc("pop_push_-20_5", 1, -20, 5, 1, 0);
    cyc("drain1", 0, 0, 0, 1, 0);
    cyc("drain2", 0, 0, 0, 1, 0);
    cyc("idle", 0, 0, 0, 0, 0);

    // Fill to DEPTH, offer a fifth, then drain in order
    cyc("fill0", 1, 1, 2, 0, 0);
    cyc("fill1", 1, -128, 255, 0, 0);
    cyc("fill2", 1, 127, 255, 0, 0);
    cyc("fill3", 1, -1, 0, 0, 0);
    cyc("fifth_offer", 1, 50, 50, 0, 0);
    for (int i = 0; i < 4; i++) cyc($sformatf("drain_full%0d", i), 0, 0, 0, 1, 0);

    // Hold level 2 with simultaneous push/pop across pointer wrap
    cyc("lvl2_a", 1, 10, 20, 0, 0);
    cyc("lvl2_b", 1, -30, 40, 0, 0);
    for (int i = 0; i < 6; i++) begin
      rx = int'($urandom_range(0, 255)) - 128;
      ry = int'($urandom_range(0, 255));
      cyc($sformatf("pushpop%0d", i), 1, rx, ry, 1, 0);
    end
    cyc("lvl2_drain_a", 0, 0, 0, 1, 0);
    cyc("lvl2_drain_b", 0, 0, 0, 1, 0);

    // Flush at level 3 with a concurrent push
    cyc("pre_flush0", 1, 5, 6, 0, 0);
    cyc("pre_flush1", 1, 7, 8, 0, 0);
    cyc("pre_flush2", 1, 9, 10, 0, 0);
    cyc("flush_push", 1, 1, 1, 0, 1);
    cyc("after_flush", 0, 0, 0, 0, 0);
    cyc("flush_pop", 0, 0, 0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rx = int'($urandom_range(0, 255)) - 128;
      ry = int'($urandom_range(0, 255));
      cyc($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rx, ry,
          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-stream empties the FIFO without a clock edge
    cyc("pre_rst0", 1, 3, 4, 0, 0);
    cyc("pre_rst1", 1, 5, 6, 0, 0);
    b_in_sync = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    qx.delete();
    qy.delete();
    check_all("async_reset", zero3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 1, -3, 10, 0, 0);
    cyc("post_rst_pop", 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
